stack_ctrl: RTL
===============

Name: stack_ctrl

Overview:
- Sequencing controller that sits directly upstream of the stack-pointer register.
- Accepts push/pop requests from the datapath and performs the data-memory access.
- Drives the SP register's next-value input and write strobe.
- Tracks stack depth and flags overflow/underflow; after reset, re-seeds the SP register to its top-of-stack value.

Parameters:
- DW, 16, data and address width.
- SP_TOP, 8191, empty-stack SP value (top of data memory, 0x1FFF).
- DEPTH_MAX, 1024, maximum number of stacked words.

Ports:
- CLK  in  1  system clock; all controller state on posedge.
- RST_N  in  1  asynchronous active-low reset.
- push_req  in  1  push request, sampled when req_ready=1.
- pop_req  in  1  pop request, sampled when req_ready=1.
- push_data  in  DW  word to push, sampled with push_req.
- req_ready  out  1  controller idle, can accept a request.
- sp_in  in  DW  current SP register value.
- sp_next  out  DW  next SP value, to the SP register A input.
- sp_write  out  1  SP register write strobe, to regWrite.
- mem_addr  out  DW  data-memory address.
- mem_wdata  out  DW  data-memory write data.
- mem_we  out  1  data-memory write enable.
- mem_re  out  1  data-memory read enable; rdata valid one cycle later.
- mem_rdata  in  DW  data-memory read data.
- pop_data  out  DW  popped word, held until the next pop.
- pop_valid  out  1  one-cycle pulse when pop_data updates.
- depth  out  11  words currently on stack.
- overflow  out  1  sticky: push rejected at full stack.
- underflow  out  1  sticky: pop rejected at empty stack.
- clr_err  in  1  synchronous clear of overflow/underflow.

Behaviour:
- Reset (RST_N=0, async) → state INIT.
  - All outputs 0 except sp_next=SP_TOP; depth=0; flags=0.
  - Any in-flight access is aborted; no mem_we is issued after reset asserts.
- INIT (1 cycle): sp_write=1, sp_next=SP_TOP, req_ready=0 → IDLE.
  - The SP register samples on the following negedge, so sp_in=SP_TOP before the first request.
- Stack convention: empty-descending.
  - Push writes mem[SP], then SP = SP-1.
  - Pop sets SP = SP+1, then reads mem[SP].
- IDLE: req_ready=1.
  - On a posedge with push_req=1: latch addr_q=sp_in and data_q=push_data.
    - depth==DEPTH_MAX → set overflow, stay IDLE.
    - Otherwise → PUSH.
  - On a posedge with pop_req=1 (and push_req=0): latch addr_q=sp_in+1.
    - depth==0 → set underflow, stay IDLE.
    - Otherwise → POP_RD.
  - push_req and pop_req both high: push wins; pop is dropped silently, no flag.
- PUSH (1 cycle): req_ready=0.
  - mem_addr=addr_q, mem_wdata=data_q, mem_we=1.
  - sp_next=addr_q-1, sp_write=1.
  - depth+1 at the cycle end → IDLE.
- POP_RD (1 cycle): req_ready=0.
  - mem_addr=addr_q, mem_re=1.
  - sp_next=addr_q, sp_write=1.
  - depth-1 → POP_WAIT.
- POP_WAIT (1 cycle): capture pop_data=mem_rdata, pop_valid=1 the next cycle → IDLE.
- Latency:
  - Push: accept edge k, memory write and SP update during cycle k+1, req_ready high again at k+2.
  - Pop: pop_valid high in cycle k+3, next request accepted at k+3.
- Addresses come only from addr_q, never directly from sp_in. This keeps mem_addr stable across the negedge SP update.
- sp_next is driven only when sp_write=1; otherwise it holds its last value.
- Arithmetic is modulo 2^DW; wrap cannot occur inside the legal depth range.
- Error flags:
  - Sticky until clr_err.
  - If clr_err coincides with a new error, the new error wins (flag stays 1).
  - Rejected requests produce no memory access and no SP write.
- RST_N asserted in PUSH/POP_RD/POP_WAIT: immediate return to INIT.
  - depth resets to 0.
  - The SP register is re-seeded by INIT; stack contents are logically discarded.

Decomposition:
- stack_pkg holds:
  - the state enum (INIT, IDLE, PUSH, POP_RD, POP_WAIT);
  - SP_TOP, DEPTH_MAX and DW defaults;
  - the depth-width constant, clog2(DEPTH_MAX)+1.
- Single module; no sub-module is needed. The depth counter and the flags are small enough to stay inline.

Test Plan:
- Reset release → INIT cycle with sp_write=1 and sp_next=8191; req_ready=1 from the next cycle; depth=0 and both flags 0.
- Push 0xBEEF from empty → mem_we with mem_addr=8191 and mem_wdata=0xBEEF; sp_next=8190; depth=1. Then pop → mem_re with mem_addr=8191; pop_data=0xBEEF with a pop_valid pulse; sp_next=8191; depth=0.
- Pop at empty → underflow=1, no mem_re, no sp_write. Then clr_err=1 for one cycle → underflow=0.
- 1024 pushes of 0..1023, then a 1025th push → overflow=1; depth stays 1024; sp_in stays 7167; no mem_we on the rejected push.
- push_req and pop_req both asserted at depth 3 → push performed, depth=4, no pop_valid, no flag.
- RST_N dropped during the PUSH cycle → mem_we deasserts immediately; after release, INIT re-seeds SP to 8191 and depth=0.

Source files
------------

// File: rtl/stack_pkg.sv
// stack_pkg: shared constants, depth width and FSM state type for the stack controller.
package stack_pkg;
    localparam int DW_DEF        = 16;
    localparam int SP_TOP_DEF    = 8191;
    localparam int DEPTH_MAX_DEF = 1024;
    localparam int DEPTH_W       = $clog2(DEPTH_MAX_DEF) + 1;
    typedef enum logic [2:0] {INIT, IDLE, PUSH, POP_RD, POP_WAIT} state_e;
endpackage

// File: rtl/stack_ctrl_if.sv
// stack_ctrl_if: datapath request, SP register and data-memory signals of the stack controller.
interface stack_ctrl_if import stack_pkg::*; #(
    parameter int DW  = DW_DEF,
    parameter int DPW = DEPTH_W
);
    logic          push_req;
    logic          pop_req;
    logic [DW-1:0] push_data;
    logic          req_ready;
    logic [DW-1:0] sp_in;
    logic [DW-1:0] sp_next;
    logic          sp_write;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic          mem_re;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] pop_data;
    logic          pop_valid;
    logic [DPW-1:0] depth;
    logic          overflow;
    logic          underflow;
    logic          clr_err;
    modport slave (
        input  push_req, pop_req, push_data, sp_in, mem_rdata, clr_err,
        output req_ready, sp_next, sp_write, mem_addr, mem_wdata, mem_we, mem_re,
               pop_data, pop_valid, depth, overflow, underflow
    );
    modport master (
        output push_req, pop_req, push_data, sp_in, mem_rdata, clr_err,
        input  req_ready, sp_next, sp_write, mem_addr, mem_wdata, mem_we, mem_re,
               pop_data, pop_valid, depth, overflow, underflow
    );
endinterface

// File: rtl/stack_ctrl.sv
// stack_ctrl: empty-descending stack sequencer driving the SP register and data memory,
// with depth tracking and sticky overflow/underflow flags.
module stack_ctrl import stack_pkg::*; #(
    parameter int DW        = DW_DEF,
    parameter int SP_TOP    = SP_TOP_DEF,
    parameter int DEPTH_MAX = DEPTH_MAX_DEF
) (
    input  logic        CLK,
    input  logic        RST_N,
    stack_ctrl_if.slave bus
);
    localparam int DPW = $clog2(DEPTH_MAX) + 1;
    state_e         state_q, state_d;
    logic [DW-1:0]  addr_q, addr_d, data_q, data_d;
    logic [DW-1:0]  pop_data_q, pop_data_d, sp_next_q;
    logic [DPW-1:0] depth_q, depth_d;
    logic           ovf_q, ovf_d, udf_q, udf_d, pop_valid_q, pop_valid_d;
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= INIT;
            addr_q      <= '0;
            data_q      <= '0;
            pop_data_q  <= '0;
            sp_next_q   <= DW'(SP_TOP);
            depth_q     <= '0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
            pop_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            pop_data_q  <= pop_data_d;
            sp_next_q   <= bus.sp_next;
            depth_q     <= depth_d;
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
            pop_valid_q <= pop_valid_d;
        end
    end
    // Memory address always comes from addr_q so it stays put while the SP register updates mid-cycle.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        data_d        = data_q;
        depth_d       = depth_q;
        pop_data_d    = pop_data_q;
        pop_valid_d   = 1'b0;
        ovf_d         = ovf_q && !bus.clr_err;
        udf_d         = udf_q && !bus.clr_err;
        bus.req_ready = 1'b0;
        bus.sp_write  = 1'b0;
        bus.sp_next   = sp_next_q;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_we    = 1'b0;
        bus.mem_re    = 1'b0;
        case (state_q)
            INIT: begin
                bus.sp_write = RST_N;
                bus.sp_next  = DW'(SP_TOP);
                state_d      = IDLE;
            end
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.push_req) begin
                    addr_d = bus.sp_in;
                    data_d = bus.push_data;
                    if (depth_q == DPW'(DEPTH_MAX)) ovf_d = 1'b1;
                    else state_d = PUSH;
                end else if (bus.pop_req) begin
                    addr_d = bus.sp_in + DW'(1);
                    if (depth_q == '0) udf_d = 1'b1;
                    else state_d = POP_RD;
                end
            end
            PUSH: begin
                bus.mem_addr  = addr_q;
                bus.mem_wdata = data_q;
                bus.mem_we    = 1'b1;
                bus.sp_next   = addr_q - DW'(1);
                bus.sp_write  = 1'b1;
                depth_d       = depth_q + DPW'(1);
                state_d       = IDLE;
            end
            POP_RD: begin
                bus.mem_addr = addr_q;
                bus.mem_re   = 1'b1;
                bus.sp_next  = addr_q;
                bus.sp_write = 1'b1;
                depth_d      = depth_q - DPW'(1);
                state_d      = POP_WAIT;
            end
            POP_WAIT: begin
                pop_data_d  = bus.mem_rdata;
                pop_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = INIT;
        endcase
    end
    assign bus.pop_data  = pop_data_q;
    assign bus.pop_valid = pop_valid_q;
    assign bus.depth     = depth_q;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = udf_q;
endmodule
